// File: rtl/mult_add_pkg.sv
// Shared constants for the multiply-add pipeline: default widths, saturation bounds, result fit.
// Latency: none (package of constants and a combinational helper function).
// Backpressure: not applicable. Optional feature macro: MULT_ADD_SAT_EN selects saturate instead of wrap.
package mult_add_pkg;

    localparam int DW_D      = 8;
    localparam int OW_D      = 16;
    localparam int C_SHIFT_D = 7;

    // Signed bounds of the default result width
    localparam logic [OW_D-1:0] SMAX = {1'b0, {(OW_D-1){1'b1}}};
    localparam logic [OW_D-1:0] SMIN = {1'b1, {(OW_D-1){1'b0}}};

    // Fit an OW+1-bit sum into OW bits: clamp when the top two bits disagree, else plain wrap
    function automatic logic [OW_D-1:0] sat_fit(input logic [OW_D:0] sum);
        logic [OW_D-1:0] res;
        res = OW_D'(sum);
`ifdef MULT_ADD_SAT_EN
        if (sum[OW_D] != sum[OW_D-1]) begin
            res = sum[OW_D] ? SMIN : SMAX;
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/mult_add_sat.sv
// Fits the OW+1-bit pipeline sum to OW bits; saturates and flags when MULT_ADD_SAT_EN is defined, else wraps.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mult_add_sat
    import mult_add_pkg::*;
#(
    parameter int OW = OW_D
) (
    input  logic [OW:0]   i_sum,
`ifdef MULT_ADD_SAT_EN
    output logic          o_sat,
`endif
    output logic [OW-1:0] o_fit
);

`ifdef MULT_ADD_SAT_EN
    localparam logic [OW-1:0] L_SMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] L_SMIN = {1'b1, {(OW-1){1'b0}}};

    logic w_ovf;

    // Overflow out of OW signed bits shows up as the two top sum bits disagreeing
    assign w_ovf = i_sum[OW] ^ i_sum[OW-1];
    assign o_sat = w_ovf;

    // Clamp toward the sign of the true (OW+1-bit) sum on overflow
    always_comb begin
        o_fit = OW'(i_sum);
        if (w_ovf) begin
            o_fit = i_sum[OW] ? L_SMIN : L_SMAX;
        end
    end
`else
    // Two's-complement wrap: keep the low OW bits
    assign o_fit = OW'(i_sum);
`endif

endmodule

// File: rtl/mult_add_pipe.sv
// Two-stage signed s = a*b + (c <<< C_SHIFT), or a*b + previous s when acc_in; MULT_ADD_SAT_EN adds saturation + sat_flag.
// Latency: 2 cycles from accepted beat to val_out; 1 beat/cycle throughput while ack_out is high.
// Backpressure: rdy_in = ~v1 | ~val_out | ack_out (no skid); at most 2 beats held while ack_out is low.
module mult_add_pipe
    import mult_add_pkg::*;
#(
    parameter int DW      = DW_D,
    parameter int OW      = OW_D,
    parameter int C_SHIFT = C_SHIFT_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic          acc_in,
    input  logic          val_in,
    output logic          rdy_in,
    output logic [OW-1:0] s,
    output logic          val_out,
`ifdef MULT_ADD_SAT_EN
    output logic          sat_flag,
`endif
    input  logic          ack_out
);

    // Stage 1 state
    logic            r_v1;
    logic [2*DW-1:0] r_mult;
    logic [DW-1:0]   r_c;
    logic            r_acc;

    // Stage 2 state
    logic            r_vout;
    logic [OW-1:0]   r_s;
`ifdef MULT_ADD_SAT_EN
    logic            r_sat;
    logic            w_sat;
`endif

    logic            w_en1;
    logic            w_en2;
    logic [2*DW-1:0] w_a_ext;
    logic [2*DW-1:0] w_b_ext;
    logic [2*DW-1:0] w_prod;
    logic [OW:0]     w_mult_ext;
    logic [OW:0]     w_c_sh;
    logic [OW:0]     w_addend;
    logic [OW:0]     w_sum;
    logic [OW-1:0]   w_fit;

    // Stage 2 advances when empty or being consumed; stage 1 when empty or stage 2 advances
    assign w_en2  = ~r_vout | ack_out;
    assign w_en1  = ~r_v1 | w_en2;
    assign rdy_in = w_en1;

    // Sign-extended operands make the low 2*DW bits of the unsigned product the signed product
    assign w_a_ext = {{DW{a[DW-1]}}, a};
    assign w_b_ext = {{DW{b[DW-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Both addends widened to OW+1 bits so the add itself can never overflow
    assign w_mult_ext = {{(OW+1-2*DW){r_mult[2*DW-1]}}, r_mult};
    assign w_c_sh     = {{(OW+1-DW){r_c[DW-1]}}, r_c} << C_SHIFT;
    assign w_addend   = r_acc ? {r_s[OW-1], r_s} : w_c_sh;
    assign w_sum      = w_mult_ext + w_addend;

    mult_add_sat #(
        .OW    (OW)
    ) u_sat (
        .i_sum (w_sum),
`ifdef MULT_ADD_SAT_EN
        .o_sat (w_sat),
`endif
        .o_fit (w_fit)
    );

    // Stage 1 data: loads only on an accepted beat, no reset needed since v1 qualifies it
    always_ff @(posedge clk) begin
        if (w_en1 && val_in) begin
            r_mult <= w_prod;
            r_c    <= c;
            r_acc  <= acc_in;
        end
    end

    // Valid bits and result register; s keeps its value after consumption so acc beats chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_vout <= 1'b0;
            r_s    <= '0;
`ifdef MULT_ADD_SAT_EN
            r_sat  <= 1'b0;
`endif
        end else begin
            if (w_en1) begin
                r_v1 <= val_in;
            end
            if (w_en2) begin
                r_vout <= r_v1;
                if (r_v1) begin
                    r_s   <= w_fit;
`ifdef MULT_ADD_SAT_EN
                    r_sat <= w_sat;
`endif
                end
            end
        end
    end

    assign s       = r_s;
    assign val_out = r_vout;
`ifdef MULT_ADD_SAT_EN
    assign sat_flag = r_sat;
`endif

endmodule

// File: tb/tb_mult_add_pipe.sv
// Directed bench for mult_add_pipe at DW=8, OW=16, C_SHIFT=7; builds with or without MULT_ADD_SAT_EN.
// Latency: checks the 2-cycle accept-to-valid timing and 1 beat/cycle streaming.
// Backpressure: checks stall with ack_out low, ordered drain, and reset flush.
module tb_mult_add_pipe;

    typedef struct {
        int a;
        int b;
        int c;
        int acc;
        int exp_s;
        int exp_sat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        acc_in;
    logic        val_in;
    logic        rdy_in;
    logic [15:0] s;
    logic        val_out;
    logic        ack_out;
`ifdef MULT_ADD_SAT_EN
    logic        sat_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mult_add_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .acc_in   (acc_in),
        .val_in   (val_in),
        .rdy_in   (rdy_in),
        .s        (s),
        .val_out  (val_out),
`ifdef MULT_ADD_SAT_EN
        .sat_flag (sat_flag),
`endif
        .ack_out  (ack_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(got), $signed(exp));
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int va, input int vb, input int vc, input int vacc, input logic vv);
        a      = 8'(va);
        b      = 8'(vb);
        c      = 8'(vc);
        acc_in = (vacc != 0);
        val_in = vv;
    endtask

    vec_t        vt[11];
    logic [15:0] got_q[$];
    logic        accepted;

    initial begin
        // Single-beat vectors, evaluated in order (acc entries depend on the previous s)
        vt[0]  = '{3, -4, 2, 0, 244, 0};
        vt[1]  = '{-128, -128, 127, 0, 32640, 0};
`ifdef MULT_ADD_SAT_EN
        vt[2]  = '{127, 127, 0, 1, 32767, 1};
`else
        vt[2]  = '{127, 127, 0, 1, -16767, 0};
`endif
        vt[3]  = '{-128, 127, -128, 0, -32640, 0};
        vt[4]  = '{0, 0, -1, 0, -128, 0};
        vt[5]  = '{2, 3, 0, 1, -122, 0};
        vt[6]  = '{-128, -128, 127, 0, 32640, 0};
        vt[7]  = '{1, 1, 0, 1, 32641, 0};
        vt[8]  = '{-128, 127, -128, 0, -32640, 0};
        vt[9]  = '{-128, 1, 0, 1, -32768, 0};
`ifdef MULT_ADD_SAT_EN
        vt[10] = '{-1, 1, 0, 1, -32768, 1};
`else
        vt[10] = '{-1, 1, 0, 1, 32767, 0};
`endif

        rst     = 1'b1;
        ack_out = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk1("rst_val_out", val_out, 1'b0);
        chk16("rst_s", s, 16'd0);
        chk1("rst_rdy_in", rdy_in, 1'b1);
`ifdef MULT_ADD_SAT_EN
        chk1("rst_sat", sat_flag, 1'b0);
`endif
        step();

        // Table: one beat each, ack held high, result exactly two cycles after acceptance
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].c, vt[i].acc, 1'b1);
            @(negedge clk);
            chk1($sformatf("vec%0d_rdy", i), rdy_in, 1'b1);
            step();
            val_in = 1'b0;
            @(negedge clk);
            chk1($sformatf("vec%0d_early", i), val_out, 1'b0);
            step();
            @(negedge clk);
            chk1($sformatf("vec%0d_val", i), val_out, 1'b1);
            chk16($sformatf("vec%0d_s", i), s, 16'(vt[i].exp_s));
`ifdef MULT_ADD_SAT_EN
            chk1($sformatf("vec%0d_sat", i), sat_flag, (vt[i].exp_sat != 0));
`endif
            step();
        end

        // Stream: 4 back-to-back beats give 4 back-to-back results, s = 2*(k+1)
        for (int t = 0; t < 7; t++) begin
            if (t < 4) drive(t + 1, 2, 0, 0, 1'b1);
            else       val_in = 1'b0;
            @(negedge clk);
            chk1($sformatf("strm%0d_rdy", t), rdy_in, 1'b1);
            chk1($sformatf("strm%0d_val", t), val_out, (t >= 2 && t <= 5));
            if (t >= 2 && t <= 5) chk16($sformatf("strm%0d_s", t), s, 16'(2 * (t - 1)));
            step();
        end

        // Backpressure: two beats fill the pipe, third is refused while s stays frozen
        ack_out = 1'b0;
        drive(5, 1, 0, 0, 1'b1);
        @(negedge clk);
        chk1("bp_rdy0", rdy_in, 1'b1);
        step();
        drive(6, 1, 0, 0, 1'b1);
        @(negedge clk);
        chk1("bp_rdy1", rdy_in, 1'b1);
        chk1("bp_val1", val_out, 1'b0);
        step();
        drive(7, 1, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("bp_stall%0d_rdy", k), rdy_in, 1'b0);
            chk1($sformatf("bp_stall%0d_val", k), val_out, 1'b1);
            chk16($sformatf("bp_stall%0d_s", k), s, 16'd5);
            step();
        end
        ack_out = 1'b1;
        got_q.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (val_out) got_q.push_back(s);
            accepted = val_in && rdy_in;
            step();
            if (accepted) val_in = 1'b0;
        end
        chk_int("bp_count", got_q.size(), 3);
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            chk16($sformatf("bp_res%0d", k), got_q[k], 16'(5 + k));
        end

        // Reset mid-flight: accepted beat is flushed, s clears, next acc beat adds to 0
        drive(9, 9, 0, 0, 1'b1);
        step();
        val_in = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1($sformatf("flush%0d_val", k), val_out, 1'b0);
            chk16($sformatf("flush%0d_s", k), s, 16'd0);
            step();
        end
        drive(2, 5, 3, 1, 1'b1);
        step();
        val_in = 1'b0;
        @(negedge clk);
        chk1("post_rst_early", val_out, 1'b0);
        step();
        @(negedge clk);
        chk1("post_rst_val", val_out, 1'b1);
        chk16("post_rst_s", s, 16'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
